// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg: AES S-box tables and shared types for the SubBytes datapath | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int NBYTES_C = 16;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_t;

  localparam aes_byte_t AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam aes_byte_t AES_INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

`default_nettype wire

// File: rtl/aes_sbox_lane.sv
// ---------------------------------------------------------------------------
// aes_sbox_lane: one-byte combinational forward/inverse S-box lookup | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_sbox_lane
  import aes_pkg::*;
(
  input  aes_byte_t in_byte,
  input  logic      inv,
  output aes_byte_t out_byte
);

  assign out_byte = inv ? AES_INV_SBOX[in_byte] : AES_SBOX[in_byte];

endmodule

`default_nettype wire

// File: rtl/aes_sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_engine: iterative SubBytes/InvSubBytes, LANES bytes per clock | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NBYTES*8-1:0]   in_state,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBYTES*8-1:0]   out_state,
  output logic                  busy
);

  localparam int STEPS   = NBYTES / LANES;
  localparam int CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W   = $clog2(NBYTES);
  localparam int LANE_SH = $clog2(LANES);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end
  if (NBYTES != NBYTES_C) begin : g_bad_nbytes
    $error("aes_sub_bytes_engine: NBYTES must be 16");
  end

  sb_state_t                    state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  aes_byte_t [NBYTES-1:0]       work_q, work_d;
  logic                         inv_q, inv_d;
  logic [NBYTES*8-1:0]          out_state_q, out_state_d;
  logic                         out_valid_q, out_valid_d;
  logic                         busy_q, busy_d;

  logic                         w_accept;
  logic [IDX_W-1:0]             w_base;
  logic [IDX_W-1:0]             w_lane_idx [LANES];
  aes_byte_t                    w_lane_out [LANES];

  // Lane l always works on byte cnt*LANES + l of the working register.
  assign w_base = IDX_W'(cnt_q) << LANE_SH;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_idx[l] = w_base + IDX_W'(l);

    aes_sbox_lane u_lane (
      .in_byte  (work_q[w_lane_idx[l]]),
      .inv      (inv_q),
      .out_byte (w_lane_out[l])
    );
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    inv_d       = inv_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          work_d  = in_state;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[w_lane_idx[l]] = w_lane_out[l];
        end
        if (cnt_q == C_CNT_LAST) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_state_d = work_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // A consumed result may be replaced by a new block in the same edge.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            work_d  = in_state;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      inv_q       <= 1'b0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_sub_bytes_engine: directed + random bench, one engine per LANES value | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_sub_bytes_engine;

  localparam int NDUT = 5;
  localparam int LANES_TAB [NDUT] = '{4, 1, 2, 8, 16};
  localparam int LAT_TAB   [NDUT] = '{5, 17, 9, 3, 2};

  logic         clk;
  logic         rst_n;
  logic         in_valid_a  [NDUT];
  logic         in_ready_a  [NDUT];
  logic [127:0] in_state_a  [NDUT];
  logic         in_inv_a    [NDUT];
  logic         out_valid_a [NDUT];
  logic         out_ready_a [NDUT];
  logic [127:0] out_state_a [NDUT];
  logic         busy_a      [NDUT];

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    aes_sub_bytes_engine #(.LANES(LANES_TAB[k]), .NBYTES(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[k]),
      .in_ready  (in_ready_a[k]),
      .in_state  (in_state_a[k]),
      .in_inv    (in_inv_a[k]),
      .out_valid (out_valid_a[k]),
      .out_ready (out_ready_a[k]),
      .out_state (out_state_a[k]),
      .busy      (busy_a[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference S-box from its definition: GF(2^8) inverse then affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] l, r;
    l = b << n;
    r = b >> (8 - n);
    return l | r;
  endfunction

  task automatic build_model();
    logic [7:0] binv, s;
    for (int x = 0; x < 256; x++) begin
      binv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) binv = 8'(y);
      end
      s = binv ^ rotl8(binv, 1) ^ rotl8(binv, 2) ^ rotl8(binv, 3) ^ rotl8(binv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv ? inv_tab[st[8*i +: 8]] : fwd_tab[st[8*i +: 8]];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Offers one block, then scrambles the inputs every cycle until out_valid.
  task automatic run_block(input int k, input logic [127:0] st, input logic inv,
                           output logic [127:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready_a[k] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_valid_a[k] = 1'b1;
    in_state_a[k] = st;
    in_inv_a[k]   = inv;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    lat = 1;
    while (!out_valid_a[k] && lat < 40) begin
      in_state_a[k] = {$urandom, $urandom, $urandom, $urandom};
      in_inv_a[k]   = ~in_inv_a[k];
      @(posedge clk); #1;
      lat++;
    end
    res = out_state_a[k];
  endtask

  initial begin
    logic [127:0] st, res, res2, exp_a;
    logic         inv;
    int           lat, k;

    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      in_valid_a[i]  = 1'b0;
      in_state_a[i]  = '0;
      in_inv_a[i]    = 1'b0;
      out_ready_a[i] = 1'b1;
    end
    build_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset in_ready",  128'(in_ready_a[0]),  128'd1);
    chk("reset out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("reset busy",      128'(busy_a[0]),      128'd0);
    chk("reset out_state", out_state_a[0],       128'd0);

    // Inverse directed vector
    st = {{11{8'h52}}, 40'h93_E1_4D_89_76};
    run_block(0, st, 1'b1, res, lat);
    chk("inv vector", res, {{11{8'h48}}, 40'h22_E0_65_F2_0F});
    chk("inv vector latency", 128'(lat), 128'd5);

    // Forward corner values on every LANES configuration
    for (int d = 0; d < NDUT; d++) begin
      run_block(d, 128'd0, 1'b0, res, lat);
      chk($sformatf("fwd zero L%0d", LANES_TAB[d]), res, {16{8'h63}});
      chk($sformatf("latency L%0d", LANES_TAB[d]), 128'(lat), 128'(LAT_TAB[d]));
      run_block(d, 128'h53, 1'b0, res, lat);
      chk($sformatf("fwd 53 L%0d", LANES_TAB[d]), res, {{15{8'h63}}, 8'hED});
    end

    // FIPS-197 round trip
    st = 128'h00112233445566778899AABBCCDDEEFF;
    run_block(0, st, 1'b0, res, lat);
    chk("fips forward", res, model(st, 1'b0));
    run_block(0, res, 1'b1, res2, lat);
    chk("fips roundtrip", res2, st);

    // Random blocks across all configurations
    for (int i = 0; i < 1000; i++) begin
      k   = i % NDUT;
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom & 1);
      run_block(k, st, inv, res, lat);
      chk($sformatf("random %0d L%0d", i, LANES_TAB[k]), res, model(st, inv));
    end

    // Backpressure: result held while out_ready is low
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    st    = {$urandom, $urandom, $urandom, $urandom};
    exp_a = model(st, 1'b0);
    run_block(0, st, 1'b0, res, lat);
    chk("bp first result", res, exp_a);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp out_state stable", out_state_a[0], exp_a);
      chk("bp out_valid held", 128'(out_valid_a[0]), 128'd1);
      chk("bp in_ready low", 128'(in_ready_a[0]), 128'd0);
    end
    st = {$urandom, $urandom, $urandom, $urandom};
    in_valid_a[0]  = 1'b1;
    in_state_a[0]  = st;
    in_inv_a[0]    = 1'b1;
    out_ready_a[0] = 1'b1;
    #1;
    chk("bp in_ready follows out_ready", 128'(in_ready_a[0]), 128'd1);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    chk("bp back-to-back busy", 128'(busy_a[0]), 128'd1);
    chk("bp back-to-back out_valid", 128'(out_valid_a[0]), 128'd0);
    lat = 1;
    while (!out_valid_a[0] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp second result", out_state_a[0], model(st, 1'b1));
    chk("bp second latency", 128'(lat), 128'd5);

    // Reset during RUN cycle 2
    @(posedge clk); #1;
    in_valid_a[0] = 1'b1;
    in_state_a[0] = {$urandom, $urandom, $urandom, $urandom};
    in_inv_a[0]   = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst pre busy", 128'(busy_a[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("rst async out_state", out_state_a[0], 128'd0);
    chk("rst async in_ready", 128'(in_ready_a[0]), 128'd1);
    chk("rst async busy", 128'(busy_a[0]), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst no stray out_valid", 128'(out_valid_a[0]), 128'd0);
    st = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, st, 1'b1, res, lat);
    chk("rst next block", res, model(st, 1'b1));
    chk("rst next latency", 128'(lat), 128'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
